// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared state, op-code and ALUOp constants for the multiply sequencer
package mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;

    localparam logic [1:0] ALUOP_RTYPE = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

endpackage

// File: rtl/mul_seq_ctrl_alu_control.sv
// rtl/mul_seq_ctrl_alu_control.sv - R-type funct decode into 3-bit ALU op codes
module ALU_Control
    import mul_seq_pkg::*;
(
    input  logic [5:0] funct_i,
    input  logic [1:0] ALUOp_i,
    output logic [2:0] ALUCtrl_o
);

    // Anything that is not a recognised R-type funct falls back to ADD.
    always_comb begin
        ALUCtrl_o = OP_ADD;
        if (ALUOp_i == ALUOP_RTYPE) begin
            case (funct_i)
                FUNCT_ADD: ALUCtrl_o = OP_ADD;
                FUNCT_SUB: ALUCtrl_o = OP_SUB;
                FUNCT_AND: ALUCtrl_o = OP_AND;
                FUNCT_OR:  ALUCtrl_o = OP_OR;
                FUNCT_MUL: ALUCtrl_o = OP_MUL;
                default:   ALUCtrl_o = OP_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - single-cycle ALU ops plus iterative shift-add multiplier with pipeline stall
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             ready_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    state_t           state;
    state_t           state_next;
    logic [2:0]       op;
    logic             accept;
    logic             last_iter;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] alu_result;

    ALU_Control u_alu_control (
        .funct_i   (funct_i),
        .ALUOp_i   (ALUOp_i),
        .ALUCtrl_o (op)
    );

    assign accept    = start_i && (state != ST_MUL);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign acc_sum   = acc + (mplier[0] ? mcand : '0);

    // Single-cycle ops resolve straight from the live operands at the accept edge.
    always_comb begin
        alu_result = data1_i + data2_i;
        case (op)
            OP_SUB:  alu_result = data1_i - data2_i;
            OP_AND:  alu_result = data1_i & data2_i;
            OP_OR:   alu_result = data1_i | data2_i;
            default: alu_result = data1_i + data2_i;
        endcase
    end

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; DONE accepts a new op just like IDLE.
    always_comb begin
        state_next = state;
        ready_o    = 1'b1;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (op == OP_MUL) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                ready_o = 1'b0;
                stall_o = 1'b1;
                if (last_iter) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o = 1'b1;
                if (accept) begin
                    state_next = (op == OP_MUL) ? ST_MUL : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture at accept, then one shift-add iteration per MUL cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            result_o <= '0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                cnt    <= '0;
                acc    <= '0;
                mcand  <= data1_i;
                mplier <= data2_i;
            end else begin
                result_o <= alu_result;
            end
        end else if (state == ST_MUL) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
                result_o <= acc_sum;
            end
        end
    end

endmodule
